// File: rtl/stack_port_ctrl.sv
// Valid/ready front end for the Stack LIFO: turns push/pop commands into registered strobes,
// tracks occupancy, and returns popped words. Optional saturating error count: STACK_CTRL_ERR_CNT_EN.
module stack_port_ctrl #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 7,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_d,
  input  logic [WIDTH-1:0] stk_q,
  output logic [CNT_W-1:0] level,
  output logic             err_ovf,
  output logic             err_unf,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_Q = 2'd1;
  localparam logic [1:0] CAPT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [1:0] state;
  logic       accept;
  logic       push_ok;
  logic       pop_ok;
  logic       ovf_now;
  logic       unf_now;

  // Pops only enter when no response is pending, or when the pending one is retired this edge.
  assign cmd_ready = cmd_op ? ((state == IDLE) || (state == RESP && rsp_ready)) : 1'b1;
  assign accept    = cmd_valid && cmd_ready;
  assign push_ok   = accept && !cmd_op && (level != FULL);
  assign pop_ok    = accept &&  cmd_op && (level != '0);
  assign ovf_now   = accept && !cmd_op && (level == FULL);
  assign unf_now   = accept &&  cmd_op && (level == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_d     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so every term reads the pre-edge value of level/state.
      stk_push <= push_ok;
      stk_pop  <= pop_ok;
      err_ovf  <= ovf_now;
      err_unf  <= unf_now;
      if (push_ok) stk_d <= cmd_data;

      if (push_ok)     level <= level + CNT_W'(1);
      else if (pop_ok) level <= level - CNT_W'(1);

      case (state)
        IDLE:   if (pop_ok) state <= WAIT_Q;
        WAIT_Q: state <= CAPT;
        CAPT: begin
          rsp_data  <= stk_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop_ok ? WAIT_Q : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_CTRL_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  err_cnt <= '0;
    else if ((ovf_now || unf_now) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Directed bench for stack_port_ctrl with a behavioural stack and a queue-based response scoreboard.
module tb_stack_port_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 7;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_d;
  logic [WIDTH-1:0] stk_q;
  logic [CNT_W-1:0] level;
  logic             err_ovf;
  logic             err_unf;
  logic [7:0]       err_cnt;

  stack_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d), .stk_q(stk_q),
    .level(level), .err_ovf(err_ovf), .err_unf(err_unf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO: q is registered on the pop edge.
  logic [WIDTH-1:0] mem [DEPTH];
  int               sp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp    <= 0;
      stk_q <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_d;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_q <= mem[sp-1];
      sp    <= sp - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } exp_t;
  exp_t exp_q[$];

  int   push_cnt = 0, pop_cnt = 0, ovf_cnt = 0, unf_cnt = 0;
  logic prev_valid = 1'b0;

  // Monitor: each new response is checked against the scoreboard head, including its latency.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      prev_valid = rsp_valid;
      if (stk_push) push_cnt++;
      if (stk_pop)  pop_cnt++;
      if (err_ovf)  ovf_cnt++;
      if (err_unf)  unf_cnt++;
      if (stk_push && stk_pop) check("strobe_exclusive", 32'd1, 32'd0);
    end
  end

  task automatic issue(input logic op, input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] exp_data, input bit exp_rsp);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    #1;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready && exp_rsp) exp_q.push_back('{exp_data, cyc});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    issue(1'b0, d, '0, 1'b0);
  endtask

  task automatic pop(input logic [WIDTH-1:0] e);
    issue(1'b1, '0, e, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},     32'(level), 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"},  rsp_data, 32'd0);
    check({tag, "_stk_push"},  {31'd0, stk_push}, 32'd0);
    check({tag, "_stk_pop"},   {31'd0, stk_pop}, 32'd0);
    check({tag, "_stk_d"},     stk_d, 32'd0);
    check({tag, "_err_ovf"},   {31'd0, err_ovf}, 32'd0);
    check({tag, "_err_unf"},   {31'd0, err_unf}, 32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] ERR_AFTER_UNF = `ifdef STACK_CTRL_ERR_CNT_EN 8'd1 `else 8'd0 `endif;
  localparam logic [7:0] ERR_AFTER_OVF = `ifdef STACK_CTRL_ERR_CNT_EN 8'd2 `else 8'd0 `endif;

  initial begin
    int b_push, b_pop, b_ovf, b_unf, waited;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0; rsp_ready = 1'b1;
    idle(3);
    check_reset_outputs("init");
    reset = 1'b0;
    #1;
    check("idle_push_ready", {31'd0, cmd_ready}, 32'd1);

    // Pop on an empty stack: flagged and dropped.
    b_pop = pop_cnt; b_unf = unf_cnt;
    issue(1'b1, '0, '0, 1'b0);
    idle(4);
    check("unf_pulses", 32'(unf_cnt - b_unf), 32'd1);
    check("unf_no_pop", 32'(pop_cnt - b_pop), 32'd0);
    check("unf_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("unf_err_cnt", 32'(err_cnt), 32'(ERR_AFTER_UNF));

    // Basic LIFO order with back-to-back pops.
    b_push = push_cnt; b_pop = pop_cnt;
    push(32'hA1); push(32'hB2); push(32'hC3);
    check("level_3", 32'(level), 32'd3);
    pop(32'hC3); pop(32'hB2); pop(32'hA1);
    idle(6);
    check("level_0_after_pops", 32'(level), 32'd0);
    check("push_strobes_3", 32'(push_cnt - b_push), 32'd3);
    check("pop_strobes_3", 32'(pop_cnt - b_pop), 32'd3);

    // Fill to DEPTH, then overflow.
    b_push = push_cnt; b_ovf = ovf_cnt;
    for (int i = 0; i < DEPTH; i++) push(32'h10 + 32'(i));
    check("level_full", 32'(level), 32'd7);
    push(32'hFF);
    idle(3);
    check("ovf_pulses", 32'(ovf_cnt - b_ovf), 32'd1);
    check("ovf_no_push", 32'(push_cnt - b_push), 32'd7);
    check("ovf_level_held", 32'(level), 32'd7);
    check("ovf_err_cnt", 32'(err_cnt), 32'(ERR_AFTER_OVF));
    for (int i = DEPTH - 1; i >= 0; i--) pop(32'h10 + 32'(i));
    idle(6);
    check("level_0_after_drain", 32'(level), 32'd0);

    // Stalled response holds data and blocks further pops.
    push(32'h11); push(32'h22);
    rsp_ready = 1'b0;
    pop(32'h22);
    waited = 0;
    while (!rsp_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_pop_blocked", {31'd0, cmd_ready}, 32'd0);
      check("stall_rsp_hold", rsp_data, 32'h22);
      check("stall_valid_hold", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_pop_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.push_back('{32'h11, cyc});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    idle(6);
    check("level_0_after_stall", 32'(level), 32'd0);

    // Push during WAIT_Q keeps LIFO order.
    push(32'h01);
    pop(32'h01);
    check("in_wait_q_pop_strobe", {31'd0, stk_pop}, 32'd1);
    push(32'h55);
    pop(32'h55);
    idle(6);
    check("level_0_after_wait_q_push", 32'(level), 32'd0);

    // Asynchronous reset in WAIT_Q abandons the pop.
    push(32'h77);
    pop(32'h77);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midpop");
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    idle(8);
    check("post_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("post_reset_level", 32'(level), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
